spmm_scheduler: RTL and testbench

Sequences one full SPMM (H x W) pass: drives the SPMM valid strobe, monitors WH BRAM write strobes to track progress, and detects subgraph boundaries from the per-row metadata. For each completed subgraph it emits a descriptor (base WH address, node count) to the downstream attention stage over a valid/ready queue. It pauses SPMM when that queue nears full and signals pass completion.

---
 rtl/gat_pkg.sv | 32 +++
 rtl/sg_desc_fifo.sv | 80 ++++++++
 rtl/spmm_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_spmm_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT SPMM / attention datapath.
//   sched_state_t : SPMM pass scheduler states
//   desc_t        : subgraph descriptor {WH base address, node count}
//   make_desc     : builds a descriptor, clamping a zero node count to 1
package gat_pkg;

    localparam int NUM_ROWS       = 2708;
    localparam int NUM_NODE_WIDTH = 8;
    localparam int WH_ADDR_W      = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [WH_ADDR_W-1:0]      base;
        logic [NUM_NODE_WIDTH-1:0] nodes;
    } desc_t;

    function automatic desc_t make_desc(input logic [WH_ADDR_W-1:0]      base,
                                        input logic [NUM_NODE_WIDTH-1:0] nodes);
        desc_t d;
        d.base  = base;
        d.nodes = (nodes == '0) ? NUM_NODE_WIDTH'(1) : nodes;
        return d;
    endfunction

endpackage

// File: rtl/sg_desc_fifo.sv
// First-word-fall-through descriptor FIFO with two push lanes.
//   push0_i/data0_i : first entry to enqueue
//   push1_i/data1_i : second entry, only honoured together with push0_i
//   pop_i           : dequeue head (ignored when empty)
//   data_o/empty_o  : head entry, valid while !empty_o
//   count_o         : occupancy, used by the scheduler's free-slot compare
//   overflow_o      : at least one requested entry was dropped this cycle
// A single WH write can close two subgraphs (a forced partial plus a
// one-node subgraph), hence the second lane. Entries that do not fit are
// dropped in lane order.
module sg_desc_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 26,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0_i,
    input  logic [W-1:0]  data0_i,
    input  logic          push1_i,
    input  logic [W-1:0]  data1_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, we0, we1;
    logic [1:0]    n_req, n_acc;
    logic [CW:0]   room;

    // NOTE: every variable gets a default at the top of a combinational block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        pop   = pop_i && (count_q != '0);
        n_req = 2'(push0_i) + 2'(push0_i && push1_i);
        // A same-cycle pop frees a slot for an incoming entry.
        room  = (CW+1)'(DEPTH) - (CW+1)'(count_q) + (CW+1)'(pop);
        if ((CW+1)'(n_req) <= room) n_acc = n_req;
        else                        n_acc = room[1:0];
        overflow_o = (n_acc != n_req);
        we0        = (n_acc != 2'd0);
        we1        = (n_acc == 2'd2);
        wr_ptr_d   = wr_ptr_q + PW'(n_acc);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(n_acc) - CW'(pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count
    // define validity, and empty_o masks stale contents after reset.
    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_ptr_q]          <= data0_i;
        if (we1) mem_q[wr_ptr_q + PW'(1)] <= data1_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/spmm_scheduler.sv
// Sequences one SPMM pass and turns the WH write stream into subgraph
// descriptors for the attention stage.
//   start_i / busy_o / done_o        : pass control and status
//   spmm_valid_o                     : SPMM enable, paused when the queue nears full
//   wh_we_i, wh_addr_i,
//   wh_num_nodes_i, wh_src_flag_i    : observed WH BRAM writes with row metadata
//   desc_valid_o/ready_i/base_o/nodes_o : descriptor queue head (valid/ready)
//   row_count_o                      : WH rows written this pass
//   err_o                            : sticky protocol/overflow error, cleared on start
module spmm_scheduler
    import gat_pkg::*;
#(
    parameter  int NUM_ROWS     = gat_pkg::NUM_ROWS,
    parameter  int DESC_DEPTH   = 8,
    parameter  int STALL_MARGIN = 2,
    localparam int ROW_W        = $clog2(NUM_ROWS + 1),
    localparam int CNT_W        = $clog2(DESC_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      spmm_valid_o,
    input  logic                      wh_we_i,
    input  logic [WH_ADDR_W-1:0]      wh_addr_i,
    input  logic [NUM_NODE_WIDTH-1:0] wh_num_nodes_i,
    input  logic                      wh_src_flag_i,
    output logic                      desc_valid_o,
    input  logic                      desc_ready_i,
    output logic [WH_ADDR_W-1:0]      desc_base_o,
    output logic [NUM_NODE_WIDTH-1:0] desc_nodes_o,
    output logic [ROW_W-1:0]          row_count_o,
    output logic                      err_o
);

    sched_state_t              state_q, state_d;
    logic                      spmm_valid_q, spmm_valid_d;
    logic [ROW_W-1:0]          row_count_q, row_count_d;
    logic                      err_q, err_d;
    logic                      open_q, open_d;
    logic [WH_ADDR_W-1:0]      base_q, base_d;
    logic [NUM_NODE_WIDTH-1:0] nodes_q, nodes_d;
    logic [NUM_NODE_WIDTH-1:0] rem_q, rem_d;
    logic                      push0_q, push0_d, push1_q, push1_d;
    desc_t                     desc0_q, desc0_d, desc1_q, desc1_d;

    logic [NUM_NODE_WIDTH-1:0] seen;
    logic                      counting, rows_done, near_full;
    logic                      fifo_empty, fifo_overflow;
    logic [CNT_W-1:0]          fifo_count;
    desc_t                     head;

    assign counting  = (state_q == S_RUN) || (state_q == S_STALL);
    assign seen      = nodes_q - rem_q;
    assign near_full = (int'(fifo_count) >= DESC_DEPTH - STALL_MARGIN);

    // Subgraph tracking, row counting and descriptor generation.
    always_comb begin
        row_count_d = row_count_q;
        err_d       = err_q || fifo_overflow;
        open_d      = open_q;
        base_d      = base_q;
        nodes_d     = nodes_q;
        rem_d       = rem_q;
        push0_d     = 1'b0;
        push1_d     = 1'b0;
        desc0_d     = '0;
        desc1_d     = '0;

        if (state_q == S_IDLE && start_i) begin
            row_count_d = '0;
            err_d       = 1'b0;
            open_d      = 1'b0;
            base_d      = '0;
            nodes_d     = '0;
            rem_d       = '0;
        end else if (counting && wh_we_i) begin
            if (row_count_q != ROW_W'(NUM_ROWS)) row_count_d = row_count_q + ROW_W'(1);
            if (wh_src_flag_i) begin
                if (open_q) begin
                    // New source row while a subgraph is open: flush what we have.
                    err_d   = 1'b1;
                    push0_d = 1'b1;
                    desc0_d = make_desc(base_q, seen);
                end
                if (wh_num_nodes_i <= NUM_NODE_WIDTH'(1)) begin
                    open_d = 1'b0;
                    if (wh_num_nodes_i == '0) err_d = 1'b1;
                    // Lane 1 is only needed when lane 0 already holds a partial.
                    if (open_q) begin
                        push1_d = 1'b1;
                        desc1_d = make_desc(wh_addr_i, wh_num_nodes_i);
                    end else begin
                        push0_d = 1'b1;
                        desc0_d = make_desc(wh_addr_i, wh_num_nodes_i);
                    end
                end else begin
                    open_d  = 1'b1;
                    base_d  = wh_addr_i;
                    nodes_d = wh_num_nodes_i;
                    rem_d   = wh_num_nodes_i - NUM_NODE_WIDTH'(1);
                end
            end else if (open_q) begin
                rem_d = rem_q - NUM_NODE_WIDTH'(1);
                if (rem_q == NUM_NODE_WIDTH'(1)) begin
                    open_d  = 1'b0;
                    push0_d = 1'b1;
                    desc0_d = make_desc(base_q, nodes_q);
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == S_DRAIN && open_q) begin
            // Pass ended mid-subgraph: emit the rows that did arrive.
            err_d   = 1'b1;
            open_d  = 1'b0;
            push0_d = 1'b1;
            desc0_d = make_desc(base_q, seen);
        end
    end

    assign rows_done = counting && (row_count_d == ROW_W'(NUM_ROWS));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN: begin
                if (rows_done)      state_d = S_DRAIN;
                else if (near_full) state_d = S_STALL;
            end
            S_STALL: begin
                if (rows_done)       state_d = S_DRAIN;
                else if (!near_full) state_d = S_RUN;
            end
            S_DRAIN: begin
                if (fifo_empty && !push0_q && !push1_q && !open_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Valid rises one cycle after entering RUN and falls on the leaving edge.
        spmm_valid_d = (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            spmm_valid_q <= 1'b0;
            row_count_q  <= '0;
            err_q        <= 1'b0;
            open_q       <= 1'b0;
            base_q       <= '0;
            nodes_q      <= '0;
            rem_q        <= '0;
            push0_q      <= 1'b0;
            push1_q      <= 1'b0;
            desc0_q      <= '0;
            desc1_q      <= '0;
        end else begin
            state_q      <= state_d;
            spmm_valid_q <= spmm_valid_d;
            row_count_q  <= row_count_d;
            err_q        <= err_d;
            open_q       <= open_d;
            base_q       <= base_d;
            nodes_q      <= nodes_d;
            rem_q        <= rem_d;
            push0_q      <= push0_d;
            push1_q      <= push1_d;
            desc0_q      <= desc0_d;
            desc1_q      <= desc1_d;
        end
    end

    sg_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .W     ($bits(desc_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0_i    (push0_q),
        .data0_i    (desc0_q),
        .push1_i    (push1_q),
        .data1_i    (desc1_q),
        .pop_i      (desc_ready_i),
        .data_o     (head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (fifo_overflow)
    );

    assign busy_o       = counting || (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DONE);
    assign spmm_valid_o = spmm_valid_q;
    assign desc_valid_o = !fifo_empty;
    assign desc_base_o  = head.base;
    assign desc_nodes_o = head.nodes;
    assign row_count_o  = row_count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_spmm_scheduler.sv
// Bench for spmm_scheduler with a 12-row pass, 8-deep queue, margin 2.
// Descriptors expected from the driven rows go into a queue; a monitor pops
// and compares every accepted descriptor.
module tb_spmm_scheduler;
    import gat_pkg::*;

    localparam int NR    = 12;
    localparam int ROW_W = $clog2(NR + 1);

    logic                      clk = 1'b0;
    logic                      rst_n, start_i, busy_o, done_o, spmm_valid_o;
    logic                      wh_we_i, wh_src_flag_i, desc_valid_o, desc_ready_i, err_o;
    logic [WH_ADDR_W-1:0]      wh_addr_i, desc_base_o;
    logic [NUM_NODE_WIDTH-1:0] wh_num_nodes_i, desc_nodes_o;
    logic [ROW_W-1:0]          row_count_o;

    spmm_scheduler #(.NUM_ROWS(NR), .DESC_DEPTH(8), .STALL_MARGIN(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .spmm_valid_o   (spmm_valid_o),
        .wh_we_i        (wh_we_i),
        .wh_addr_i      (wh_addr_i),
        .wh_num_nodes_i (wh_num_nodes_i),
        .wh_src_flag_i  (wh_src_flag_i),
        .desc_valid_o   (desc_valid_o),
        .desc_ready_i   (desc_ready_i),
        .desc_base_o    (desc_base_o),
        .desc_nodes_o   (desc_nodes_o),
        .row_count_o    (row_count_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                      src;
        logic [NUM_NODE_WIDTH-1:0] n;
        logic [WH_ADDR_W-1:0]      addr;
        int                        n_exp;
        desc_t                     e0;
        desc_t                     e1;
    } vec_t;

    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    desc_t exp_q[$];
    vec_t  tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic desc_t dsc(input int b, input int n);
        desc_t d;
        d.base  = WH_ADDR_W'(b);
        d.nodes = NUM_NODE_WIDTH'(n);
        return d;
    endfunction

    function automatic vec_t mk(input bit src, input int n, input int addr, input int n_exp,
                                input int b0, input int n0, input int b1, input int n1);
        vec_t v;
        v.src   = src;
        v.n     = NUM_NODE_WIDTH'(n);
        v.addr  = WH_ADDR_W'(addr);
        v.n_exp = n_exp;
        v.e0    = dsc(b0, n0);
        v.e1    = dsc(b1, n1);
        return v;
    endfunction

    // Scoreboard monitor: compare every descriptor accepted by downstream.
    always @(negedge clk) begin
        if (rst_n && desc_valid_o && desc_ready_i) begin
            check("desc_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                desc_t e;
                e = exp_q.pop_front();
                check("desc_base", int'(desc_base_o), int'(e.base));
                check("desc_nodes", int'(desc_nodes_o), int'(e.nodes));
            end
        end
        if (done_o) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input logic src, input int n, input int addr);
        wh_we_i        = 1'b1;
        wh_src_flag_i  = src;
        wh_num_nodes_i = NUM_NODE_WIDTH'(n);
        wh_addr_i      = WH_ADDR_W'(addr);
        tick();
    endtask

    task automatic idle(input int k);
        wh_we_i       = 1'b0;
        wh_src_flag_i = 1'b0;
        repeat (k) tick();
    endtask

    task automatic single(input int addr);
        exp_q.push_back(dsc(addr, 1));
        drive_row(1'b1, 1, addr);
    endtask

    task automatic start_pass();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("start_busy", int'(busy_o), 1);
        check("start_valid_lat1", int'(spmm_valid_o), 0);
        check("start_err_clear", int'(err_o), 0);
        @(negedge clk);
        check("start_valid_lat2", int'(spmm_valid_o), 1);
    endtask

    task automatic apply_table();
        foreach (tbl[i]) begin
            if (tbl[i].n_exp >= 1) exp_q.push_back(tbl[i].e0);
            if (tbl[i].n_exp >= 2) exp_q.push_back(tbl[i].e1);
            drive_row(tbl[i].src, int'(tbl[i].n), int'(tbl[i].addr));
        end
        idle(0);
    endtask

    task automatic wait_done(input int exp_done);
        bit got = 1'b0;
        idle(0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", int'(got), 1);
        @(negedge clk);
        check("done_one_cycle", int'(done_o), 0);
        check("idle_after_done", int'(busy_o), 0);
        check("done_count", done_cnt, exp_done);
        check("sb_empty", exp_q.size(), 0);
        check("row_count_end", int'(row_count_o), NR);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n = 1'b0; start_i = 1'b0; wh_we_i = 1'b0; wh_src_flag_i = 1'b0;
        wh_addr_i = '0; wh_num_nodes_i = '0; desc_ready_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_spmm_valid", int'(spmm_valid_o), 0);
        check("rst_desc_valid", int'(desc_valid_o), 0);
        check("rst_row_count", int'(row_count_o), 0);
        check("rst_err", int'(err_o), 0);

        // Pass 1: four clean 3-node subgraphs.
        tbl.delete();
        for (int g = 0; g < 4; g++) begin
            tbl.push_back(mk(1'b1, 3, 3*g,     0, 0, 0, 0, 0));
            tbl.push_back(mk(1'b0, 0, 3*g + 1, 0, 0, 0, 0, 0));
            tbl.push_back(mk(1'b0, 0, 3*g + 2, 1, 3*g, 3, 0, 0));
        end
        desc_ready_i = 1'b1;
        start_pass();
        apply_table();
        wait_done(1);
        check("p1_err", int'(err_o), 0);

        // Pass 2: single-node subgraphs under backpressure.
        tick();
        desc_ready_i = 1'b0;
        start_pass();
        for (int a = 0; a < 5; a++) single(a);
        idle(4);
        @(negedge clk);
        check("below_margin_run", int'(spmm_valid_o), 1);
        single(5);
        idle(3);
        @(negedge clk);
        check("margin_stall", int'(spmm_valid_o), 0);
        check("stall_busy", int'(busy_o), 1);
        single(6);
        single(7);
        idle(3);
        @(negedge clk);
        check("full_no_err", int'(err_o), 0);
        check("full_head_valid", int'(desc_valid_o), 1);
        check("full_head_base", int'(desc_base_o), 0);
        check("full_head_nodes", int'(desc_nodes_o), 1);
        drive_row(1'b1, 1, 8);
        idle(3);
        @(negedge clk);
        check("overflow_err", int'(err_o), 1);
        check("overflow_rows", int'(row_count_o), 9);
        tick();
        desc_ready_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (spmm_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        check("resume_run", int'(got), 1);
        for (int a = 9; a < 12; a++) single(a);
        wait_done(2);
        check("p2_err_sticky", int'(err_o), 1);

        // Pass 3: protocol errors, zero-node row, double push, open at end.
        tbl.delete();
        tbl.push_back(mk(1'b1, 4, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 0, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 3, 2,  1, 0, 2, 0, 0));
        tbl.push_back(mk(1'b0, 0, 3,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 0, 4,  1, 2, 3, 0, 0));
        tbl.push_back(mk(1'b1, 0, 5,  1, 5, 1, 0, 0));
        tbl.push_back(mk(1'b1, 2, 6,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b0, 0, 7,  1, 6, 2, 0, 0));
        tbl.push_back(mk(1'b1, 1, 8,  1, 8, 1, 0, 0));
        tbl.push_back(mk(1'b1, 5, 9,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1'b1, 1, 10, 2, 9, 1, 10, 1));
        tbl.push_back(mk(1'b1, 3, 11, 1, 11, 1, 0, 0));
        start_pass();
        apply_table();
        wait_done(3);
        check("p3_err", int'(err_o), 1);

        // Pass 4: reset while stalled with a full-ish queue.
        tick();
        desc_ready_i = 1'b0;
        start_pass();
        for (int a = 0; a < 6; a++) single(a);
        idle(3);
        @(negedge clk);
        check("pre_rst_stall", int'(spmm_valid_o), 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_desc_valid", int'(desc_valid_o), 0);
        check("midrst_spmm_valid", int'(spmm_valid_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_rows", int'(row_count_o), 0);

        // Pass 5: start_i during RUN is ignored.
        tick();
        desc_ready_i = 1'b1;
        start_pass();
        for (int a = 0; a < 4; a++) single(a);
        idle(1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("restart_rows_kept", int'(row_count_o), 4);
        check("restart_busy", int'(busy_o), 1);
        check("restart_valid", int'(spmm_valid_o), 1);
        for (int a = 4; a < 12; a++) single(a);
        wait_done(4);
        check("p5_err", int'(err_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
